// File: rtl/onedconv_pkg.sv
// Shared types, default widths and helpers for the 1D-convolution output collector.
package onedconv_pkg;
   localparam int DEF_BITWIDTH_DATA      = 16;
   localparam int DEF_BITWIDTH_OF_COLUMS = 11;
   localparam int DEF_DEPTH              = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/onedconv_out_collector_if.sv
// Capture strobe, row control and drain stream of the 1D-convolution output collector.
interface onedconv_out_collector_if #(
   parameter int BITWIDTH_DATA      = 16,
   parameter int BITWIDTH_OF_COLUMS = 11
);
   logic                          ONEDCONV_OCOL_Start;
   logic [BITWIDTH_OF_COLUMS-1:0] ONEDCONV_OCOL_Of_Colums;
   logic                          ONEDCONV_OCOL_Oen;
   logic [BITWIDTH_DATA-1:0]      ONEDCONV_OCOL_Data;
   logic                          ONEDCONV_OCOL_Out_Ready;
   logic                          ONEDCONV_OCOL_Out_Valid;
   logic [BITWIDTH_DATA-1:0]      ONEDCONV_OCOL_Out_Data;
   logic                          ONEDCONV_OCOL_Out_Last;
   logic                          ONEDCONV_OCOL_Busy;
   logic                          ONEDCONV_OCOL_Row_Done;
   logic                          ONEDCONV_OCOL_Err;

   modport master (
      output ONEDCONV_OCOL_Start, ONEDCONV_OCOL_Of_Colums, ONEDCONV_OCOL_Oen,
             ONEDCONV_OCOL_Data, ONEDCONV_OCOL_Out_Ready,
      input  ONEDCONV_OCOL_Out_Valid, ONEDCONV_OCOL_Out_Data, ONEDCONV_OCOL_Out_Last,
             ONEDCONV_OCOL_Busy, ONEDCONV_OCOL_Row_Done, ONEDCONV_OCOL_Err
   );

   modport slave (
      input  ONEDCONV_OCOL_Start, ONEDCONV_OCOL_Of_Colums, ONEDCONV_OCOL_Oen,
             ONEDCONV_OCOL_Data, ONEDCONV_OCOL_Out_Ready,
      output ONEDCONV_OCOL_Out_Valid, ONEDCONV_OCOL_Out_Data, ONEDCONV_OCOL_Out_Last,
             ONEDCONV_OCOL_Busy, ONEDCONV_OCOL_Row_Done, ONEDCONV_OCOL_Err
   );
endinterface

// File: rtl/onedconv_row_ram.sv
// Row buffer: simple dual-port RAM, one write port, registered read, no array reset.
module onedconv_row_ram
   import onedconv_pkg::*;
#(
   parameter int  WIDTH = DEF_BITWIDTH_DATA,
   parameter int  DEPTH = DEF_DEPTH,
   localparam int AW    = addr_w(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/onedconv_out_collector.sv
// Collects one row of convolution results per Start, then drains it over valid/ready.
//   state | meaning
//   IDLE  | waiting for Start; stray strobes set Err
//   FILL  | writing one word per Oen until count_q words are stored
//   DRAIN | streaming the row out; first cycle primes the RAM read
module onedconv_out_collector
   import onedconv_pkg::*;
#(
   parameter int BITWIDTH_DATA      = DEF_BITWIDTH_DATA,
   parameter int BITWIDTH_OF_COLUMS = DEF_BITWIDTH_OF_COLUMS,
   parameter int DEPTH              = DEF_DEPTH
) (
   input logic                     ONEDCONV_OCOL_Clk,
   input logic                     ONEDCONV_OCOL_Clr,
   onedconv_out_collector_if.slave bus
);
   localparam int ADDR_W = addr_w(DEPTH);
   localparam int CNT_W  = (ADDR_W + 1 > BITWIDTH_OF_COLUMS) ? ADDR_W + 1 : BITWIDTH_OF_COLUMS;

   state_e                   state_q, state_d;
   logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr, ram_waddr;
   logic [CNT_W-1:0]         count_q, count_d, last_idx, cols_ext;
   logic                     prime_q, prime_d, valid_q, valid_d;
   logic                     err_q, err_d, row_done_q, row_done_d;
   logic                     ram_we, handshake, cols_legal, wr_at_last, rd_at_last;
   logic [BITWIDTH_DATA-1:0] ram_rdata;

   assign cols_ext   = CNT_W'(bus.ONEDCONV_OCOL_Of_Colums);
   assign cols_legal = (cols_ext != '0) && (cols_ext <= CNT_W'(DEPTH));
   assign last_idx   = count_q - CNT_W'(1);
   assign wr_at_last = (CNT_W'(wr_ptr_q) == last_idx);
   assign rd_at_last = (CNT_W'(rd_ptr_q) == last_idx);
   assign handshake  = valid_q & bus.ONEDCONV_OCOL_Out_Ready;
   // Read one word ahead on a handshake so a held-high ready drains 1 word/cycle.
   assign rd_addr    = rd_ptr_q + ADDR_W'(handshake);

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      prime_d    = 1'b0;
      valid_d    = valid_q;
      err_d      = err_q;
      row_done_d = 1'b0;
      ram_we     = 1'b0;
      ram_waddr  = wr_ptr_q;
      case (state_q)
         IDLE: begin
            if (bus.ONEDCONV_OCOL_Start && cols_legal) begin
               count_d  = cols_ext;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               state_d  = FILL;
               if (bus.ONEDCONV_OCOL_Oen) begin
                  ram_we    = 1'b1;
                  ram_waddr = '0;
                  wr_ptr_d  = ADDR_W'(1);
                  if (cols_ext == CNT_W'(1)) state_d = DRAIN;
               end
            end else if (bus.ONEDCONV_OCOL_Start || bus.ONEDCONV_OCOL_Oen) begin
               err_d = 1'b1;
            end
         end
         FILL: begin
            if (bus.ONEDCONV_OCOL_Oen) begin
               ram_we = 1'b1;
               if (wr_at_last) begin
                  state_d  = DRAIN;
                  rd_ptr_d = '0;
               end else begin
                  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            if (bus.ONEDCONV_OCOL_Oen) err_d = 1'b1;
            if (!valid_q) begin
               prime_d = 1'b1;
               valid_d = prime_q;
            end else if (handshake) begin
               rd_ptr_d = rd_addr;
               if (rd_at_last) begin
                  state_d    = IDLE;
                  valid_d    = 1'b0;
                  row_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ONEDCONV_OCOL_Clk) begin
      if (ONEDCONV_OCOL_Clr) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         prime_q    <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         row_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         prime_q    <= prime_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         row_done_q <= row_done_d;
      end
   end

   onedconv_row_ram #(
      .WIDTH (BITWIDTH_DATA),
      .DEPTH (DEPTH)
   ) u_row_ram (
      .clk_i   (ONEDCONV_OCOL_Clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (bus.ONEDCONV_OCOL_Data),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

   assign bus.ONEDCONV_OCOL_Out_Valid = valid_q;
   assign bus.ONEDCONV_OCOL_Out_Data  = ram_rdata;
   assign bus.ONEDCONV_OCOL_Out_Last  = valid_q & rd_at_last;
   assign bus.ONEDCONV_OCOL_Busy      = (state_q != IDLE);
   assign bus.ONEDCONV_OCOL_Row_Done  = row_done_q;
   assign bus.ONEDCONV_OCOL_Err       = err_q;
endmodule

// File: doc/onedconv_out_collector.md
# onedconv_out_collector

Consumer side of the 1D-convolution output-enable protocol. It captures one convolution result per strobe from the output-enable generator into a row buffer until the programmed column count is reached. It then drains the row to the downstream stream/DMA port over a valid/ready handshake. It sits between the 1D-convolution datapath and the Avalon-ST/DMA write path in the Nios system.

## Interface
Parameters:
- BITWIDTH_DATA, 16, width of one convolution result.
- BITWIDTH_OF_COLUMS, 11, width of the column-count input.
- DEPTH, 1024, row-buffer entries and maximum legal column count; ADDR_W = clog2(DEPTH).

Ports:
- ONEDCONV_OCOL_Clk, in, 1, single clock, rising edge.
- ONEDCONV_OCOL_Clr, in, 1, reset; synchronous, active-high.
- ONEDCONV_OCOL_Start, in, 1, one-cycle pulse that arms capture of one row and latches Of_Colums.
- ONEDCONV_OCOL_Of_Colums, in, BITWIDTH_OF_COLUMS, number of outputs per row (1..DEPTH).
- ONEDCONV_OCOL_Oen, in, 1, write strobe from the output-enable generator.
- ONEDCONV_OCOL_Data, in, BITWIDTH_DATA, result that is valid when Oen is high.
- ONEDCONV_OCOL_Out_Ready, in, 1, downstream ready.
- ONEDCONV_OCOL_Out_Valid, out, 1, drained word valid.
- ONEDCONV_OCOL_Out_Data, out, BITWIDTH_DATA, drained word.
- ONEDCONV_OCOL_Out_Last, out, 1, high with the final word of the row.
- ONEDCONV_OCOL_Busy, out, 1, high in FILL or DRAIN.
- ONEDCONV_OCOL_Row_Done, out, 1, one-cycle pulse after the last word is accepted.
- ONEDCONV_OCOL_Err, out, 1, sticky. Set by a strobe while not in FILL, or by Start with Of_Colums equal to 0 or greater than DEPTH.

## Operation
- FSM states: IDLE, FILL, DRAIN.
- Reset values: state IDLE; wr_ptr, rd_ptr and count_q are 0. Out_Valid, Out_Last, Busy, Row_Done and Err are all 0. Out_Data is don't-care while Out_Valid is 0.
- **IDLE → FILL:** on Start with a legal Of_Colums. Latch count_q = Of_Colums and set wr_ptr = 0.
- **Illegal Start in IDLE:** Of_Colums = 0 or > DEPTH sets Err and the block stays in IDLE.
- **Start together with Oen in IDLE:** the word is captured as index 0. If count_q = 1, the next state is DRAIN directly.
- **FILL:** each Oen writes Data to mem[wr_ptr] and increments wr_ptr. The Oen that writes index count_q-1 moves the state to DRAIN with rd_ptr = 0.
- **DRAIN:** presents mem[rd_ptr].
  - A handshake occurs when Out_Valid and Out_Ready are both high; it advances rd_ptr.
  - Out_Last = Out_Valid and (rd_ptr == count_q-1).
  - The handshake on the last word returns the state to IDLE and pulses Row_Done.
- **Oen in IDLE (without Start) or in DRAIN:** the word is dropped and Err is set. Buffer contents and pointers are unchanged.
- **Start in FILL or DRAIN:** ignored, with no Err.
- **Err:** cleared only by Clr.
- **Clr mid-operation:** the FSM returns to IDLE within one cycle. All outputs take their reset values on the next edge. RAM contents are not cleared, and no Row_Done is generated.
- **Width rules:**
  - Pointers are ADDR_W bits wide.
  - Comparisons against count_q are zero-extended to max(ADDR_W+1, BITWIDTH_OF_COLUMS).
  - No pointer wraps within a row, because count_q ≤ DEPTH is guaranteed.

## Timing
- Oen is sampled every cycle, so back-to-back strobes are accepted. Capture latency is 0 extra cycles: the word is written on the sampling edge.
- **FILL → DRAIN:** Out_Valid first rises 2 cycles after the edge that writes the last word (one transition cycle plus the RAM read).
- **RAM read:** synchronous. The read address is next_rd_ptr = rd_ptr + handshake, which sustains 1 word per cycle with Out_Ready held high.
- **Backpressure:** Out_Data and Out_Last hold stable while Out_Valid=1 and Out_Ready=0. Out_Valid never drops before a handshake.
- **End of row:** Row_Done is high in the cycle after the last handshake, coincident with Busy = 0. A Start in that cycle is accepted.
- A minimum row of N words takes N fill strobes + 2 + N drain cycles with no stalls.

## Structure
- Package onedconv_pkg holds:
  - the state enum (IDLE/FILL/DRAIN);
  - default widths (BITWIDTH_DATA, BITWIDTH_OF_COLUMS);
  - the DEPTH constant;
  - a clog2-based ADDR_W function.
- Sub-module onedconv_row_ram: simple dual-port RAM, DEPTH × BITWIDTH_DATA, with one write port, one synchronous read port and no reset on the array. It is inferred as M10K.
- The top level contains the FSM, the pointers, count_q and the sticky Err. Expected size is about 200 RTL lines in total.

## Test plan
- **Basic row:** Start with Of_Colums=4, then 4 Oen strobes carrying 0x11, 0x22, 0x33, 0x44 spaced every 2 cycles, with Ready=1.
  - Required: Out_Data 0x11..0x44 on consecutive cycles.
  - Required: Out_Last only on 0x44, then a Row_Done pulse and Err=0.
- **Backpressure:** as the basic row, but Ready toggles 1,0,0,1,...
  - Required: each word held stable while stalled, none lost or duplicated, and Out_Last set on word 4 only.
- **Start and Oen together, single column:** Start with Oen in the same cycle, Of_Colums=1, Data=0xAB.
  - Required: Out_Valid rises 2 cycles later with 0xAB and Out_Last=1.
- **Dropped strobes:** Oen during DRAIN of a 3-word row.
  - Required: Err=1, the drained row unchanged.
  - Required: Err still set after the following clean row.
- **Illegal column counts:** Start with Of_Colums=0, then Of_Colums=DEPTH+1.
  - Required: Err=1, Busy stays 0, no Out_Valid.
- **Reset mid-drain:** Clr asserted during DRAIN of an 8-word row after 3 handshakes.
  - Required: all outputs return to reset values on the next edge and no Row_Done.
  - Required: a fresh 2-word row then drains correctly.
